// File: rtl/instr_fetch_unit.sv
// Purpose: instruction fetch stage. Holds the PC, fetches 16-bit words over a req/ack port and presents decoded fields.
// Latency: 1 cycle from reset release to the first imem_req; imem_ack -> instr_valid on the next cycle.
// Backpressure: instr_ready=0 holds the presented instruction and blocks the next fetch; redirects discard in-flight data.
//
// Ports:
//   clk, rst                  clock (posedge) and synchronous active-high reset
//   imem_req/imem_addr        fetch request and word address; address is stable while imem_req=1
//   imem_ack/imem_rdata       fetch completion and returned instruction word
//   redirect/redirect_pc      branch/jump restart request and its target
//   instr_valid/instr_ready   handshake to the decoder
//   op_code/op1/op2/imm       instruction fields IR[15:12], IR[11:8], IR[7:4], IR[7:0]
//   instr_pc                  address of the presented instruction
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        op_code,
  output logic [3:0]        op1,
  output logic [3:0]        op2,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;  // redirect target waiting for a stale fetch to return
  logic [15:0]       ir;

  // The address port always shows pc: pc is only updated when the current
  // request completes, so an issued request is never withdrawn or changed.
  assign imem_addr = pc;

  assign op_code = ir[15:12];
  assign op1     = ir[11:8];
  assign op2     = ir[7:4];
  assign imm     = ir[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pending_pc  <= '0;
      ir          <= '0;
      instr_pc    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Nothing in flight, so a redirect here has nothing to cancel.
          pc       <= RESET_PC;
          imem_req <= 1'b1;
          state    <= REQ;
        end

        REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              // Returned word belongs to the wrong path: drop it and
              // issue the new address straight away.
              pc <= redirect_pc;
            end else begin
              // Request is outstanding; wait for it before moving on.
              pending_pc <= redirect_pc;
              state      <= DRAIN;
            end
          end else if (imem_ack) begin
            ir          <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc + ADDR_W'(1);
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end

        DRAIN: begin
          if (imem_ack) begin
            // A redirect arriving with the ack is newer than the pending one.
            pc    <= redirect ? redirect_pc : pending_pc;
            state <= REQ;
          end else if (redirect) begin
            pending_pc <= redirect_pc;
          end
        end

        VALID: begin
          if (redirect) begin
            pc          <= redirect_pc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= REQ;
          end else if (instr_ready) begin
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end

        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  op_code;
  logic [3:0]  op1;
  logic [3:0]  op2;
  logic [7:0]  imm;
  logic [7:0]  instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .op_code    (op_code),
    .op1        (op1),
    .op2        (op2),
    .imm        (imm),
    .instr_pc   (instr_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One row per clock: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        redir;
    logic [7:0]  rpc;
    logic        rdy;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_vld;
    logic [7:0]  e_ipc;
    logic [15:0] e_ir;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic a, input logic [15:0] d, input logic rd,
                     input logic [7:0] rp, input logic y, input logic er, input logic [7:0] ea,
                     input logic ev, input logic [7:0] ep, input logic [15:0] ei);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.redir = rd; v.rpc = rp; v.rdy = y;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_ipc = ep; v.e_ir = ei;
    vq.push_back(v);
  endtask

  // Random-phase reference state: instruction stream expectations.
  logic [15:0] mem [256];
  logic [7:0]  exp_pc;
  logic        stale;
  logic        exp_valid, exp_hold, exp_fresh, have_prev;
  logic        prev_req, prev_ack;
  logic [7:0]  prev_addr, prev_ipc;
  logic [19:0] prev_fields;
  logic [15:0] w;
  int          deliveries;
  int          valid_cnt;

  function automatic logic [19:0] fields_now();
    return {op_code, op1, op2, imm};
  endfunction

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; redirect = 1'b0;
    redirect_pc = 8'h0; instr_ready = 1'b0;

    // ---------------- directed table ----------------
    //   rst   ack   rdata     redir rpc    rdy | req   addr   vld   ipc    ir
    add(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 16'h0123);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 16'hDEAD, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 16'h0123);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0123);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0123);
    add(1'b0, 1'b1, 16'hABCD, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 16'h0123);
    add(1'b0, 1'b1, 16'h5A3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'h5A3C);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 16'h5A3C);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'h40, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 16'h5A3C);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 16'h5A3C);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 16'h5A3C);
    add(1'b0, 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b0, 8'hFF, 16'h5A3C);
    add(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1, 8'h40, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 8'h40, 16'h1234);
    add(1'b0, 1'b1, 16'h7777, 1'b1, 8'h20, 1'b0, 1'b1, 8'h20, 1'b0, 8'h40, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'h30, 1'b0, 1'b1, 8'h20, 1'b0, 8'h40, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'h50, 1'b0, 1'b1, 8'h20, 1'b0, 8'h40, 16'h1234);
    add(1'b0, 1'b1, 16'h9999, 1'b0, 8'h00, 1'b0, 1'b1, 8'h50, 1'b0, 8'h40, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'h60, 1'b0, 1'b1, 8'h50, 1'b0, 8'h40, 16'h1234);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h0F0F, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 16'h0F0F);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h2468, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 16'h2468);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; imem_ack = vq[i].ack; imem_rdata = vq[i].rdata;
      redirect = vq[i].redir; redirect_pc = vq[i].rpc; instr_ready = vq[i].rdy;
      @(posedge clk);
      @(negedge clk);
      w = vq[i].e_ir;
      check($sformatf("row%0d imem_req", i),    32'(imem_req),    32'(vq[i].e_req));
      check($sformatf("row%0d imem_addr", i),   32'(imem_addr),   32'(vq[i].e_addr));
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vq[i].e_vld));
      check($sformatf("row%0d instr_pc", i),    32'(instr_pc),    32'(vq[i].e_ipc));
      check($sformatf("row%0d fields", i),      32'(fields_now()), 32'({w[15:4], w[7:0]}));
    end

    // ---------------- randomized run against stream model ----------------
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);   // idle cycle: no redirect here
    exp_pc = 8'h00; stale = 1'b0; exp_valid = 1'b0; exp_hold = 1'b0; exp_fresh = 1'b0;
    have_prev = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h0;
    prev_ipc = 8'h0; prev_fields = 20'h0; deliveries = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (have_prev) begin
        check("rnd instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (prev_req && !prev_ack) begin
          check("rnd req held", 32'(imem_req), 32'd1);
          check("rnd addr held", 32'(imem_addr), 32'(prev_addr));
        end
        if (instr_valid && exp_fresh)
          check("rnd fetched pc", 32'(instr_pc), 32'(prev_addr));
        if (instr_valid && exp_hold)
          check("rnd held instr", 32'({instr_pc, fields_now()}), 32'({prev_ipc, prev_fields}));
      end
      if (instr_valid) begin
        w = mem[instr_pc];
        check("rnd fields", 32'(fields_now()), 32'({w[15:4], w[7:0]}));
      end

      imem_ack    = imem_req && ($urandom_range(0, 2) == 0);
      imem_rdata  = imem_ack ? mem[imem_addr] : 16'($urandom);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = 8'($urandom);
      instr_ready = ($urandom_range(0, 1) == 1);

      if (instr_valid && instr_ready) begin
        check("rnd stream pc", 32'(instr_pc), 32'(exp_pc));
        deliveries++;
        exp_pc = exp_pc + 8'd1;
      end
      if (redirect) exp_pc = redirect_pc;
      exp_hold  = instr_valid && !instr_ready && !redirect;
      exp_fresh = imem_req && imem_ack && !stale && !redirect;
      exp_valid = exp_hold || exp_fresh;
      if (imem_req) begin
        if (imem_ack) stale = 1'b0;
        else if (redirect) stale = 1'b1;
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      prev_ipc = instr_pc; prev_fields = fields_now(); have_prev = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    check("rnd progress", 32'(deliveries > 100), 32'd1);

    // ---------------- zero-wait throughput ----------------
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    valid_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (instr_valid) valid_cnt++;
      imem_ack   = imem_req;
      imem_rdata = 16'($urandom);
      @(posedge clk); @(negedge clk);
    end
    check("throughput count", 32'(valid_cnt), 32'd10);
    check("throughput last pc", 32'(instr_pc), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
